// File: rtl/core_bpu_resolve_ctrl_pkg.sv
// Shared pipeline types for branch resolve and training, plus the resolve controller's
// state enum and a redirect-target helper.
package core_bpu_resolve_ctrl_pkg;

  // br_type carries the branch type field; "type" itself is a reserved word.
  typedef struct packed {
    logic        miss;
    logic [31:0] pc;
    logic        true_taken;
    logic [31:0] true_target;
    logic [1:0]  lphr;
    logic [7:0]  history;
    logic [1:0]  br_type;
  } bpu_correct_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } resolve_ctrl_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] redirect_target(input bpu_correct_t rec);
    return rec.true_taken ? rec.true_target : rec.pc + PC_STEP;
  endfunction

endpackage

// File: rtl/core_bpu_resolve_ctrl_if.sv
// Resolve-lane inputs, front-end redirect and BPU training handshake of the resolve controller.
interface core_bpu_resolve_ctrl_if;
  import core_bpu_resolve_ctrl_pkg::*;

  logic               flush_i;
  logic [1:0]         res_valid_i;
  bpu_correct_t [1:0] res_i;
  logic               redirect_valid_o;
  logic [31:0]        redirect_pc_o;
  logic               upd_valid_o;
  bpu_correct_t       upd_o;
  logic               upd_ready_i;
  logic               busy_o;
  logic [15:0]        drop_cnt_o;

  modport slave (
    input  flush_i, res_valid_i, res_i, upd_ready_i,
    output redirect_valid_o, redirect_pc_o, upd_valid_o, upd_o, busy_o, drop_cnt_o
  );

  modport master (
    output flush_i, res_valid_i, res_i, upd_ready_i,
    input  redirect_valid_o, redirect_pc_o, upd_valid_o, upd_o, busy_o, drop_cnt_o
  );

endinterface

// File: rtl/core_bpu_updq.sv
// Two-write / one-read training FIFO. The caller guarantees push_cnt_i never exceeds free space.
module core_bpu_updq #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_cnt_i,
  input  T                         push0_i,
  input  T                         push1_i,
  input  logic                     pop_i,
  output logic                     head_valid_o,
  output T                         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wr_next;

  assign wr_next = wr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_cnt_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_i);
    end
  end

  // push0 is always the older record, so it takes the lower slot.
  always_ff @(posedge clk) begin
    if (push_cnt_i != 2'd0) mem_q[wr_q] <= push0_i;
    if (push_cnt_i == 2'd2) mem_q[wr_next] <= push1_i;
  end

  assign head_valid_o = (cnt_q != '0);
  assign head_o       = head_valid_o ? mem_q[rd_q] : '0;
  assign count_o      = cnt_q;

endmodule

// File: rtl/core_bpu_resolve_ctrl.sv
// Picks the oldest mispredicting resolve, issues one registered redirect, blanks wrong-path
// resolves for a drain window and serializes surviving records into the BPU training FIFO.
module core_bpu_resolve_ctrl
  import core_bpu_resolve_ctrl_pkg::*;
#(
  parameter int UPDQ_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst,
  core_bpu_resolve_ctrl_if.slave  bus_if
);

  localparam int CW = $clog2(UPDQ_DEPTH) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 2);

  resolve_ctrl_state_e state_q, state_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                redir_valid_q, redir_valid_d;
  logic [31:0]         redir_pc_q, redir_pc_d;
  logic [15:0]         drop_q, drop_d;

  logic [1:0]   elig;
  logic         sel0, sel1, wr1, pop, head_valid;
  logic [1:0]   req, push_cnt, drops;
  logic [CW-1:0] count;
  logic [CW:0]  space;
  logic [16:0]  drop_sum;
  bpu_correct_t push0, push1, head;

  // Lane 0 is older: a lane-0 miss makes lane 1 wrong-path. Overflow drops the youngest first.
  always_comb begin
    elig     = bus_if.res_valid_i & {2{~bus_if.flush_i && (state_q == IDLE)}};
    sel0     = elig[0] & bus_if.res_i[0].miss;
    sel1     = ~sel0 & elig[1] & bus_if.res_i[1].miss;
    wr1      = elig[1] & ~sel0;
    req      = {1'b0, elig[0]} + {1'b0, wr1};
    push0    = elig[0] ? bus_if.res_i[0] : bus_if.res_i[1];
    push1    = bus_if.res_i[1];
    pop      = head_valid & bus_if.upd_ready_i;
    space    = (CW+1)'(UPDQ_DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    push_cnt = ((CW+1)'(req) > space) ? space[1:0] : req;
    drops    = req - push_cnt;
    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    case (state_q)
      IDLE: begin
        if (sel0 || sel1) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = redirect_target(sel0 ? bus_if.res_i[0] : bus_if.res_i[1]);
          if (DRAIN_CYCLES > 0) begin
            state_d = DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (bus_if.flush_i || (drain_q == DW'(1))) begin
          state_d = IDLE;
          drain_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      drain_q       <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      drop_q        <= drop_d;
    end
  end

  core_bpu_updq #(
    .DEPTH (UPDQ_DEPTH),
    .T     (bpu_correct_t)
  ) u_updq (
    .clk          (clk),
    .rst          (rst),
    .push_cnt_i   (push_cnt),
    .push0_i      (push0),
    .push1_i      (push1),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_o       (head),
    .count_o      (count)
  );

  assign bus_if.redirect_valid_o = redir_valid_q;
  assign bus_if.redirect_pc_o    = redir_pc_q;
  assign bus_if.upd_valid_o      = head_valid;
  assign bus_if.upd_o            = head;
  assign bus_if.busy_o           = (state_q == DRAIN);
  assign bus_if.drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_core_bpu_resolve_ctrl.sv
// Bench for core_bpu_resolve_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the redirect/drain/training rules.
module tb_core_bpu_resolve_ctrl;
  import core_bpu_resolve_ctrl_pkg::*;

  localparam int DEPTH     = 4;
  localparam int DRAIN_LEN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   passCount  = 0;

  core_bpu_resolve_ctrl_if bus_if ();

  core_bpu_resolve_ctrl #(
    .UPDQ_DEPTH   (DEPTH),
    .DRAIN_CYCLES (DRAIN_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Model state: queue of training records, last redirect, drop total, blanking window end.
  bpu_correct_t mq[$];
  logic         mRedirV  = 1'b0;
  logic [31:0]  mRedirPc = '0;
  int           mDrop    = 0;
  longint       cyc      = 0;
  longint       busyEnd  = -1;

  function automatic logic [31:0] targetOf(input bpu_correct_t r);
    logic [31:0] fallThrough;
    fallThrough = r.pc + 32'd4;
    return r.true_taken ? r.true_target : fallThrough;
  endfunction

  function void modelPush(input bpu_correct_t r);
    if (mq.size() < DEPTH) mq.push_back(r);
    else if (mDrop < 65535) mDrop++;
  endfunction

  function automatic bpu_correct_t modelHead();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  always @(posedge clk) begin
    bit inDrain, e0, e1, m0;
    if (rst) begin
      mq.delete();
      mRedirV  = 1'b0;
      mRedirPc = '0;
      mDrop    = 0;
      busyEnd  = cyc;
    end else begin
      inDrain = (cyc <= busyEnd);
      if (mq.size() > 0 && bus_if.upd_ready_i) void'(mq.pop_front());
      e0 = bus_if.res_valid_i[0] && !bus_if.flush_i && !inDrain;
      e1 = bus_if.res_valid_i[1] && !bus_if.flush_i && !inDrain;
      m0 = e0 && bus_if.res_i[0].miss;
      mRedirV = 1'b0;
      if (m0) begin
        mRedirV  = 1'b1;
        mRedirPc = targetOf(bus_if.res_i[0]);
      end else if (e1 && bus_if.res_i[1].miss) begin
        mRedirV  = 1'b1;
        mRedirPc = targetOf(bus_if.res_i[1]);
      end
      if (e0) modelPush(bus_if.res_i[0]);
      if (e1 && !m0) modelPush(bus_if.res_i[1]);
      if (inDrain && bus_if.flush_i) busyEnd = cyc;
      if (mRedirV && DRAIN_LEN > 0) busyEnd = cyc + DRAIN_LEN;
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    checkOutput("redirect_valid", bus_if.redirect_valid_o, mRedirV);
    checkOutput("redirect_pc", bus_if.redirect_pc_o, mRedirPc);
    checkOutput("busy", bus_if.busy_o, (cyc <= busyEnd));
    checkOutput("upd_valid", bus_if.upd_valid_o, (mq.size() > 0));
    checkOutput("upd", bus_if.upd_o, modelHead());
    checkOutput("drop_cnt", bus_if.drop_cnt_o, 16'(mDrop));
  end

  function automatic bpu_correct_t mk(input logic miss, input logic [31:0] pc, input logic taken,
                                      input logic [31:0] target, input logic [7:0] hist);
    bpu_correct_t r;
    r.miss        = miss;
    r.pc          = pc;
    r.true_taken  = taken;
    r.true_target = target;
    r.lphr        = hist[1:0];
    r.history     = hist;
    r.br_type     = hist[7:6];
    return r;
  endfunction

  function automatic bpu_correct_t randRec();
    bpu_correct_t r;
    r.miss        = ($urandom_range(0, 3) == 0);
    r.pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    r.true_taken  = 1'($urandom_range(0, 1));
    r.true_target = $urandom() & 32'hFFFF_FFFC;
    r.lphr        = 2'($urandom_range(0, 3));
    r.history     = 8'($urandom_range(0, 255));
    r.br_type     = 2'($urandom_range(0, 3));
    return r;
  endfunction

  // Drive one cycle of inputs, then advance to the next cycle's sampling point.
  task automatic applyStimulus(input logic [1:0] v, input bpu_correct_t r0, input bpu_correct_t r1,
                               input logic fl, input logic rdy);
    bus_if.res_valid_i = v;
    bus_if.res_i[0]    = r0;
    bus_if.res_i[1]    = r1;
    bus_if.flush_i     = fl;
    bus_if.upd_ready_i = rdy;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] expHist [3];
    bus_if.res_valid_i = '0;
    bus_if.res_i       = '0;
    bus_if.flush_i     = 1'b0;
    bus_if.upd_ready_i = 1'b0;
    doReset();
    checkOutput("rst_redirect_valid", bus_if.redirect_valid_o, 1'b0);
    checkOutput("rst_redirect_pc", bus_if.redirect_pc_o, 32'h0);
    checkOutput("rst_upd_valid", bus_if.upd_valid_o, 1'b0);
    checkOutput("rst_busy", bus_if.busy_o, 1'b0);

    // Lane 1 not-taken miss behind a lane 0 hit.
    applyStimulus(2'b11, mk(1'b0, 32'h1C00_0000, 1'b0, 32'h0, 8'h01),
                  mk(1'b1, 32'h1C00_0010, 1'b0, 32'h1C00_0800, 8'h02), 1'b0, 1'b0);
    checkOutput("l1miss_redirect_valid", bus_if.redirect_valid_o, 1'b1);
    checkOutput("l1miss_redirect_pc", bus_if.redirect_pc_o, 32'h1C00_0014);
    checkOutput("l1miss_busy1", bus_if.busy_o, 1'b1);
    checkOutput("l1miss_head0", bus_if.upd_o.history, 8'h01);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0);
    checkOutput("l1miss_pulse_end", bus_if.redirect_valid_o, 1'b0);
    checkOutput("l1miss_busy2", bus_if.busy_o, 1'b1);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
    checkOutput("l1miss_busy3", bus_if.busy_o, 1'b0);
    checkOutput("l1miss_head1", bus_if.upd_o.history, 8'h02);
    checkOutput("l1miss_pc_hold", bus_if.redirect_pc_o, 32'h1C00_0014);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
    checkOutput("l1miss_empty", bus_if.upd_valid_o, 1'b0);

    // Lane 0 taken miss suppresses lane 1; drain window ignores two cycles.
    doReset();
    applyStimulus(2'b11, mk(1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0100, 8'h03),
                  mk(1'b1, 32'h1C00_0044, 1'b1, 32'h1C00_0200, 8'h04), 1'b0, 1'b0);
    checkOutput("l0miss_redirect_pc", bus_if.redirect_pc_o, 32'h1C00_0100);
    checkOutput("l0miss_head", bus_if.upd_o.history, 8'h03);
    applyStimulus(2'b11, mk(1'b0, 32'h1C00_0100, 1'b0, 32'h0, 8'h05),
                  mk(1'b0, 32'h1C00_0104, 1'b0, 32'h0, 8'h06), 1'b0, 1'b0);
    checkOutput("l0miss_busy2", bus_if.busy_o, 1'b1);
    applyStimulus(2'b01, mk(1'b1, 32'h1C00_0108, 1'b1, 32'h1C00_0300, 8'h07), '0, 1'b0, 1'b0);
    checkOutput("l0miss_busy3", bus_if.busy_o, 1'b0);
    checkOutput("l0miss_ignored_miss", bus_if.redirect_valid_o, 1'b0);
    applyStimulus(2'b01, mk(1'b0, 32'h1C00_010C, 1'b0, 32'h0, 8'h08), '0, 1'b0, 1'b1);
    checkOutput("l0miss_accept_n3", bus_if.upd_o.history, 8'h08);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
    checkOutput("l0miss_empty", bus_if.upd_valid_o, 1'b0);

    // Backpressure, overflow drops, then full FIFO with a same-cycle dequeue.
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b11, mk(1'b0, 32'h2000_0000, 1'b0, 32'h0, 8'(8'h10 + 2*i)),
                    mk(1'b0, 32'h2000_0004, 1'b0, 32'h0, 8'(8'h11 + 2*i)), 1'b0, 1'b0);
    checkOutput("bp_drops", bus_if.drop_cnt_o, 16'd2);
    checkOutput("bp_head", bus_if.upd_o.history, 8'h10);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0);
    checkOutput("bp_head_stable", bus_if.upd_o.history, 8'h10);
    applyStimulus(2'b11, mk(1'b0, 32'h2000_0010, 1'b0, 32'h0, 8'h20),
                  mk(1'b0, 32'h2000_0014, 1'b0, 32'h0, 8'h21), 1'b0, 1'b1);
    checkOutput("full_deq_head", bus_if.upd_o.history, 8'h11);
    checkOutput("full_deq_drops", bus_if.drop_cnt_o, 16'd3);
    expHist = '{8'h12, 8'h13, 8'h20};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
      checkOutput("drain_order", bus_if.upd_o.history, expHist[i]);
    end
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
    checkOutput("drain_empty", bus_if.upd_valid_o, 1'b0);

    // Flush during DRAIN, then a flush together with a miss in IDLE.
    doReset();
    applyStimulus(2'b11, mk(1'b0, 32'h0000_00F0, 1'b0, 32'h0, 8'h30),
                  mk(1'b1, 32'h0000_0100, 1'b0, 32'h0000_0900, 8'h31), 1'b0, 1'b0);
    checkOutput("flush_redirect_pc", bus_if.redirect_pc_o, 32'h0000_0104);
    applyStimulus(2'b01, mk(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 8'h32), '0, 1'b1, 1'b0);
    checkOutput("flush_busy_low", bus_if.busy_o, 1'b0);
    checkOutput("flush_head_kept", bus_if.upd_o.history, 8'h30);
    applyStimulus(2'b01, mk(1'b1, 32'h0000_0400, 1'b1, 32'h0000_0500, 8'h33), '0, 1'b1, 1'b0);
    checkOutput("flush_no_redirect", bus_if.redirect_valid_o, 1'b0);
    checkOutput("flush_pc_hold", bus_if.redirect_pc_o, 32'h0000_0104);
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);
    checkOutput("flush_second_entry", bus_if.upd_o.history, 8'h31);

    // Fall-through wrap at the top of the address space, then reset mid-DRAIN.
    doReset();
    applyStimulus(2'b11, mk(1'b0, 32'h3000_0000, 1'b0, 32'h0, 8'h40),
                  mk(1'b0, 32'h3000_0004, 1'b0, 32'h0, 8'h41), 1'b0, 1'b0);
    applyStimulus(2'b01, mk(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_1234, 8'h42), '0, 1'b0, 1'b0);
    checkOutput("wrap_redirect_valid", bus_if.redirect_valid_o, 1'b1);
    checkOutput("wrap_redirect_pc", bus_if.redirect_pc_o, 32'h0000_0000);
    checkOutput("wrap_busy", bus_if.busy_o, 1'b1);
    rst = 1'b1;
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_redirect_valid", bus_if.redirect_valid_o, 1'b0);
    checkOutput("midrst_upd_valid", bus_if.upd_valid_o, 1'b0);
    checkOutput("midrst_upd", bus_if.upd_o, 78'h0);
    checkOutput("midrst_busy", bus_if.busy_o, 1'b0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(2'($urandom_range(0, 3)), randRec(), randRec(),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    end
    rst = 1'b0;
    applyStimulus(2'b00, '0, '0, 1'b0, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
